rx_header_strip: RTL and testbench



---
 rtl/rx_header_strip_pkg.sv | 34 +++
 rtl/rx_header_strip_if.sv | 39 +++
 rtl/rx_header_strip_skid.sv | 59 +++++
 rtl/rx_header_strip.sv | 156 +++++++++++++++
 tb/tb_rx_header_strip.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_header_strip_pkg.sv
// Shared definitions for the rx header-strip stage: header bit-field layout,
// FSM states and the payload byte-count helper.
package rx_header_strip_pkg;

  localparam int unsigned DATA_W         = 128;
  localparam int unsigned KEEP_W         = 4;
  localparam int unsigned NODE_W         = 8;
  localparam int unsigned CNT_W          = 32;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned ADDR_W         = 64;
  localparam int unsigned ACC_W          = 17;
  localparam int unsigned BYTES_PER_KEEP = 4;

  // Header beat (beat 0) field positions; bits [63:40] are reserved
  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_W    = 8;
  localparam int unsigned SRC_LSB  = 8;
  localparam int unsigned SRC_W    = 8;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned LEN_LSB  = 24;
  localparam int unsigned ADDR_LSB = 64;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DROP
  } state_e;

  // Bytes carried by one beat: each tkeep bit marks one 32-bit word
  function automatic logic [ACC_W-1:0] keep_bytes(input logic [KEEP_W-1:0] keep);
    return ACC_W'($countones(keep)) * ACC_W'(BYTES_PER_KEEP);
  endfunction

endpackage

// File: rtl/rx_header_strip_if.sv
// Bus bundle for rx_header_strip: inbound router stream, decoded header
// channel and outbound payload stream.
// master: environment driving the inbound stream and sinking both outputs.
// slave:  the header-strip stage itself.
interface rx_header_strip_if;
  import rx_header_strip_pkg::*;

  logic              io_in_valid;
  logic              io_in_ready;
  logic [DATA_W-1:0] io_in_tdata;
  logic [KEEP_W-1:0] io_in_tkeep;
  logic              io_in_tlast;

  logic              io_hdr_valid;
  logic              io_hdr_ready;
  logic [OPC_W-1:0]  io_hdr_opcode;
  logic [SRC_W-1:0]  io_hdr_src;
  logic [LEN_W-1:0]  io_hdr_len;
  logic [ADDR_W-1:0] io_hdr_addr;

  logic              io_pay_valid;
  logic              io_pay_ready;
  logic [DATA_W-1:0] io_pay_tdata;
  logic [KEEP_W-1:0] io_pay_tkeep;
  logic              io_pay_tlast;

  modport master (
    output io_in_valid, io_in_tdata, io_in_tkeep, io_in_tlast, io_hdr_ready, io_pay_ready,
    input  io_in_ready, io_hdr_valid, io_hdr_opcode, io_hdr_src, io_hdr_len, io_hdr_addr,
    input  io_pay_valid, io_pay_tdata, io_pay_tkeep, io_pay_tlast
  );

  modport slave (
    input  io_in_valid, io_in_tdata, io_in_tkeep, io_in_tlast, io_hdr_ready, io_pay_ready,
    output io_in_ready, io_hdr_valid, io_hdr_opcode, io_hdr_src, io_hdr_len, io_hdr_addr,
    output io_pay_valid, io_pay_tdata, io_pay_tkeep, io_pay_tlast
  );

endinterface

// File: rtl/rx_header_strip_skid.sv
// axis_skid_buffer: 2-entry registered FIFO. Ready depends only on fill
// level, so upstream never sees a combinational path from downstream ready,
// yet a push and pop in the same cycle sustain one beat per cycle.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push;
  logic             pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // Occupancy tracking
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_header_strip.sv
// rx_header_strip: splits beat 0 of each packet into a decoded header
// channel, forwards the remaining beats through a skid buffer, drops packets
// for other nodes and flags payload-length mismatches.
module rx_header_strip
  import rx_header_strip_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  rx_header_strip_if.slave  bus,
  input  logic [NODE_W-1:0] io_local_node_id,
  output logic              io_len_err,
  output logic [CNT_W-1:0]  io_pkt_cnt,
  output logic [CNT_W-1:0]  io_drop_cnt
);

  localparam int unsigned SKID_W = DATA_W + KEEP_W + 1;

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  state_e            state_q, state_d;
  logic              hdr_valid_q, hdr_valid_d;
  logic [OPC_W-1:0]  hdr_opc_q, hdr_opc_d;
  logic [SRC_W-1:0]  hdr_src_q, hdr_src_d;
  logic [LEN_W-1:0]  hdr_len_q, hdr_len_d;
  logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              len_err_q, len_err_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              in_ready;
  logic              in_fire;
  logic [ACC_W-1:0]  acc_sum;
  logic              sk_in_valid;
  logic              sk_in_ready;
  logic [SKID_W-1:0] sk_out_data;

  // Reset asserts immediately, releases on a clock edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign sk_in_valid = (state_q == PAYLOAD) && bus.io_in_valid;
  assign in_fire     = bus.io_in_valid && in_ready;
  assign acc_sum     = acc_q + keep_bytes(bus.io_in_tkeep);

  axis_skid_buffer #(.WIDTH(SKID_W)) u_skid (
    .clk_i      (clock),
    .rst_ni     (rst_n),
    .in_valid_i (sk_in_valid),
    .in_ready_o (sk_in_ready),
    .in_data_i  ({bus.io_in_tdata, bus.io_in_tkeep, bus.io_in_tlast}),
    .out_valid_o(bus.io_pay_valid),
    .out_ready_i(bus.io_pay_ready),
    .out_data_o (sk_out_data)
  );

  // Next-state: packet FSM, header register, length check, counters
  always_comb begin
    state_d     = state_q;
    hdr_valid_d = hdr_valid_q;
    hdr_opc_d   = hdr_opc_q;
    hdr_src_d   = hdr_src_q;
    hdr_len_d   = hdr_len_q;
    hdr_addr_d  = hdr_addr_q;
    acc_d       = acc_q;
    len_err_d   = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    in_ready    = 1'b0;

    // Header consumption is independent of where the FSM is
    if (hdr_valid_q && bus.io_hdr_ready) hdr_valid_d = 1'b0;

    case (state_q)
      HDR: begin
        in_ready = !hdr_valid_q || bus.io_hdr_ready;
        if (in_fire) begin
          if (bus.io_in_tdata[DST_LSB +: NODE_W] != io_local_node_id) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
            if (!bus.io_in_tlast) state_d = DROP;
          end else begin
            hdr_valid_d = 1'b1;
            hdr_opc_d   = bus.io_in_tdata[OPC_LSB +: OPC_W];
            hdr_src_d   = bus.io_in_tdata[SRC_LSB +: SRC_W];
            hdr_len_d   = bus.io_in_tdata[LEN_LSB +: LEN_W];
            hdr_addr_d  = bus.io_in_tdata[ADDR_LSB +: ADDR_W];
            pkt_cnt_d   = pkt_cnt_q + CNT_W'(1);
            if (bus.io_in_tlast) begin
              len_err_d = (bus.io_in_tdata[LEN_LSB +: LEN_W] != '0);
            end else begin
              acc_d   = '0;
              state_d = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        in_ready = sk_in_ready;
        if (in_fire) begin
          acc_d = acc_sum;
          if (bus.io_in_tlast) begin
            // hdr_len_q cannot be reloaded before this packet ends
            len_err_d = (acc_sum != {1'b0, hdr_len_q});
            state_d   = HDR;
          end
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (bus.io_in_valid && bus.io_in_tlast) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      hdr_valid_q <= 1'b0;
      hdr_opc_q   <= '0;
      hdr_src_q   <= '0;
      hdr_len_q   <= '0;
      hdr_addr_q  <= '0;
      acc_q       <= '0;
      len_err_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_opc_q   <= hdr_opc_d;
      hdr_src_q   <= hdr_src_d;
      hdr_len_q   <= hdr_len_d;
      hdr_addr_q  <= hdr_addr_d;
      acc_q       <= acc_d;
      len_err_q   <= len_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.io_in_ready   = in_ready;
  assign bus.io_hdr_valid  = hdr_valid_q;
  assign bus.io_hdr_opcode = hdr_opc_q;
  assign bus.io_hdr_src    = hdr_src_q;
  assign bus.io_hdr_len    = hdr_len_q;
  assign bus.io_hdr_addr   = hdr_addr_q;
  assign {bus.io_pay_tdata, bus.io_pay_tkeep, bus.io_pay_tlast} = sk_out_data;
  assign io_len_err  = len_err_q;
  assign io_pkt_cnt  = pkt_cnt_q;
  assign io_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rx_header_strip.sv
// Self-checking bench for rx_header_strip: directed scenarios plus a
// randomized back-to-back run against a packet-level reference model.
`timescale 1ns/1ps
module tb_rx_header_strip;

  localparam logic [7:0] LOCAL_ID = 8'h05;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [7:0]  opc;
    logic [7:0]  src;
    logic [15:0] len;
    logic [63:0] addr;
  } hdr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  local_id = LOCAL_ID;
  logic        len_err;
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;

  always #5 clk = ~clk;

  rx_header_strip_if bus();

  rx_header_strip dut (
    .clock           (clk),
    .reset           (rst_n),
    .bus             (bus),
    .io_local_node_id(local_id),
    .io_len_err      (len_err),
    .io_pkt_cnt      (pkt_cnt),
    .io_drop_cnt     (drop_cnt)
  );

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    err_pulses = 0;
  int    err_base = 0;
  int    last_err_cyc = -1;
  int    last_acc_cyc = -1;
  int    stab_err = 0;
  bit    stab_en = 1'b0;
  int    stalls = 0;
  int    exp_pkt = 0;
  int    exp_drop = 0;
  int    exp_err = 0;
  beat_t tx_q[$];
  hdr_t  exp_hdr[$];
  hdr_t  obs_hdr[$];
  beat_t exp_pay[$];
  beat_t obs_pay[$];
  int    obs_pay_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records handshakes and len_err pulses; tallies channel instability
  hdr_t  prev_h;
  beat_t prev_p;
  logic  prev_hv = 1'b0, prev_hr = 1'b0, prev_pv = 1'b0, prev_pr = 1'b0;
  always @(negedge clk) begin
    hdr_t  h;
    beat_t p;
    h = '{opc: bus.io_hdr_opcode, src: bus.io_hdr_src, len: bus.io_hdr_len, addr: bus.io_hdr_addr};
    p = '{data: bus.io_pay_tdata, keep: bus.io_pay_tkeep, last: bus.io_pay_tlast};
    if (bus.io_hdr_valid && bus.io_hdr_ready) obs_hdr.push_back(h);
    if (bus.io_pay_valid && bus.io_pay_ready) begin
      obs_pay.push_back(p);
      obs_pay_cyc.push_back(cyc);
    end
    if (len_err) begin
      err_pulses++;
      last_err_cyc = cyc;
    end
    if (stab_en && prev_hv && !prev_hr && (!bus.io_hdr_valid || h != prev_h)) stab_err++;
    if (stab_en && prev_pv && !prev_pr && (!bus.io_pay_valid || p != prev_p)) stab_err++;
    prev_h = h; prev_hv = bus.io_hdr_valid; prev_hr = bus.io_hdr_ready;
    prev_p = p; prev_pv = bus.io_pay_valid; prev_pr = bus.io_pay_ready;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_hdr.delete(); obs_pay.delete(); obs_pay_cyc.delete();
    exp_hdr.delete(); exp_pay.delete();
    exp_err = 0;
    err_base = err_pulses;
  endtask

  task automatic make_hdr(input logic [7:0] dst, input logic [7:0] opc, input logic [7:0] src,
                          input logic [15:0] len, input logic [63:0] addr, input logic last);
    beat_t b;
    tx_q.delete();
    b.data = {addr, 24'($urandom), len, dst, src, opc};
    b.keep = 4'($urandom);
    b.last = last;
    tx_q.push_back(b);
  endtask

  task automatic add_beat(input logic [3:0] keep, input logic last);
    beat_t b;
    b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.keep = keep;
    b.last = last;
    tx_q.push_back(b);
  endtask

  // Packet-level reference: what the stage must produce for the packet in tx_q
  task automatic model_pkt();
    logic [127:0] h;
    int           bytes;
    h = tx_q[0].data;
    if (h[23:16] != LOCAL_ID) begin
      exp_drop++;
      return;
    end
    exp_pkt++;
    exp_hdr.push_back('{opc: h[7:0], src: h[15:8], len: h[39:24], addr: h[127:64]});
    bytes = 0;
    for (int i = 1; i < tx_q.size(); i++) begin
      exp_pay.push_back(tx_q[i]);
      bytes += 4 * $countones(tx_q[i].keep);
    end
    if (bytes != int'(h[39:24])) exp_err++;
  endtask

  task automatic gen_random_pkt();
    int          npay;
    int          bytes;
    logic [7:0]  dst;
    logic [15:0] len;
    logic [3:0]  ks[4];
    npay  = $urandom_range(0, 4);
    dst   = ($urandom_range(0, 3) == 0) ? 8'(LOCAL_ID + 8'($urandom_range(1, 255))) : LOCAL_ID;
    bytes = 0;
    for (int i = 0; i < npay; i++) begin
      ks[i] = 4'($urandom);
      bytes += 4 * $countones(ks[i]);
    end
    len = ($urandom_range(0, 1) == 0) ? 16'(bytes) : 16'($urandom_range(0, 80));
    make_hdr(dst, 8'($urandom), 8'($urandom), len, {$urandom(), $urandom()}, npay == 0);
    for (int i = 0; i < npay; i++) add_beat(ks[i], i == npay - 1);
  endtask

  // Streams the first n beats of tx_q; entered and left at posedge+1
  task automatic send_pkt(input int n);
    int guard;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      bus.io_in_valid = 1'b1;
      bus.io_in_tdata = tx_q[i].data;
      bus.io_in_tkeep = tx_q[i].keep;
      bus.io_in_tlast = tx_q[i].last;
      guard = 0;
      forever begin
        @(negedge clk);
        if (bus.io_in_ready) break;
        stalls++;
        guard++;
        if (guard > 1000) begin
          tests++; fails++;
          $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
          break;
        end
        @(posedge clk); #1;
      end
      last_acc_cyc = cyc;
      tick();
    end
    bus.io_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (i > 4 && obs_hdr.size() >= exp_hdr.size() && obs_pay.size() >= exp_pay.size()) break;
      tick();
    end
  endtask

  task automatic test_reset();
    bus.io_in_valid = 1'b0; bus.io_in_tdata = '0; bus.io_in_tkeep = '0; bus.io_in_tlast = 1'b0;
    bus.io_hdr_ready = 1'b1; bus.io_pay_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.io_hdr_valid !== 1'b0) begin fails++; $display("FAIL reset_hdr_valid: got %b, expected 0", bus.io_hdr_valid); end
    tests++; if (bus.io_pay_valid !== 1'b0) begin fails++; $display("FAIL reset_pay_valid: got %b, expected 0", bus.io_pay_valid); end
    tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL reset_len_err: got %b, expected 0", len_err); end
    tests++; if (pkt_cnt !== 32'd0) begin fails++; $display("FAIL reset_pkt_cnt: got %0d, expected 0", pkt_cnt); end
    tests++; if (drop_cnt !== 32'd0) begin fails++; $display("FAIL reset_drop_cnt: got %0d, expected 0", drop_cnt); end
    tests++; if (bus.io_hdr_addr !== 64'd0 || bus.io_hdr_len !== 16'd0) begin fails++; $display("FAIL reset_hdr_fields: got addr %h len %h, expected 0", bus.io_hdr_addr, bus.io_hdr_len); end
    tests++; if (bus.io_pay_tdata !== 128'd0) begin fails++; $display("FAIL reset_pay_tdata: got %h, expected 0", bus.io_pay_tdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    tests++; if (bus.io_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, expected 1", bus.io_in_ready); end
    tick();
  endtask

  task automatic test_local_packet();
    clear_obs();
    make_hdr(LOCAL_ID, 8'hA5, 8'h3C, 16'd32, 64'h0123_4567_89AB_CDEF, 1'b0);
    add_beat(4'hF, 1'b0);
    add_beat(4'hF, 1'b1);
    model_pkt();
    send_pkt(tx_q.size());
    drain();
    tests++; if (obs_hdr.size() != 1) begin fails++; $display("FAIL local_hdr_count: got %0d, expected 1", obs_hdr.size()); end
    if (obs_hdr.size() > 0) begin
      tests++; if (obs_hdr[0].opc !== 8'hA5) begin fails++; $display("FAIL local_opcode: got %h, expected a5", obs_hdr[0].opc); end
      tests++; if (obs_hdr[0].src !== 8'h3C) begin fails++; $display("FAIL local_src: got %h, expected 3c", obs_hdr[0].src); end
      tests++; if (obs_hdr[0].len !== 16'd32) begin fails++; $display("FAIL local_len: got %0d, expected 32", obs_hdr[0].len); end
      tests++; if (obs_hdr[0].addr !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL local_addr: got %h, expected 0123456789abcdef", obs_hdr[0].addr); end
    end
    tests++; if (obs_pay.size() != 2) begin fails++; $display("FAIL local_pay_count: got %0d, expected 2", obs_pay.size()); end
    for (int i = 0; i < obs_pay.size() && i < 2; i++) begin
      tests++; if (obs_pay[i] !== tx_q[i+1]) begin fails++; $display("FAIL local_pay_beat%0d: got %h, expected %h", i, obs_pay[i], tx_q[i+1]); end
    end
    tests++; if (pkt_cnt !== 32'(exp_pkt)) begin fails++; $display("FAIL local_pkt_cnt: got %0d, expected %0d", pkt_cnt, exp_pkt); end
    tests++; if (err_pulses - err_base != 0) begin fails++; $display("FAIL local_len_err: got %0d pulses, expected 0", err_pulses - err_base); end
  endtask

  task automatic test_foreign_packet();
    clear_obs();
    make_hdr(8'h07, 8'h11, 8'h22, 16'd32, 64'hDEAD_BEEF_0000_0001, 1'b0);
    add_beat(4'hF, 1'b0);
    add_beat(4'hF, 1'b1);
    model_pkt();
    send_pkt(tx_q.size());
    repeat (4) tick();
    tests++; if (stalls != 0) begin fails++; $display("FAIL foreign_in_ready: got %0d stall cycles, expected 0", stalls); end
    tests++; if (obs_hdr.size() != 0 || obs_pay.size() != 0) begin fails++; $display("FAIL foreign_output: got %0d hdr %0d pay, expected 0 0", obs_hdr.size(), obs_pay.size()); end
    tests++; if (drop_cnt !== 32'(exp_drop)) begin fails++; $display("FAIL foreign_drop_cnt: got %0d, expected %0d", drop_cnt, exp_drop); end
    clear_obs();
    make_hdr(LOCAL_ID, 8'h42, 8'h99, 16'd16, 64'h0000_0000_CAFE_F00D, 1'b0);
    add_beat(4'hF, 1'b1);
    model_pkt();
    send_pkt(tx_q.size());
    drain();
    tests++; if (obs_hdr.size() != 1) begin fails++; $display("FAIL after_drop_hdr_count: got %0d, expected 1", obs_hdr.size()); end
    if (obs_hdr.size() > 0) begin
      tests++; if (obs_hdr[0] !== exp_hdr[0]) begin fails++; $display("FAIL after_drop_hdr: got %h, expected %h", obs_hdr[0], exp_hdr[0]); end
    end
    tests++; if (obs_pay.size() != 1) begin fails++; $display("FAIL after_drop_pay_count: got %0d, expected 1", obs_pay.size()); end
    tests++; if (pkt_cnt !== 32'(exp_pkt)) begin fails++; $display("FAIL after_drop_pkt_cnt: got %0d, expected %0d", pkt_cnt, exp_pkt); end
  endtask

  task automatic test_len_err();
    clear_obs();
    make_hdr(LOCAL_ID, 8'h01, 8'h02, 16'd32, 64'h1111_2222_3333_4444, 1'b0);
    add_beat(4'hF, 1'b0);
    add_beat(4'h3, 1'b1);
    model_pkt();
    send_pkt(tx_q.size());
    drain();
    tests++; if (err_pulses - err_base != 1) begin fails++; $display("FAIL lenerr_pulses: got %0d, expected 1", err_pulses - err_base); end
    tests++; if (last_err_cyc != last_acc_cyc + 1) begin fails++; $display("FAIL lenerr_timing: got cycle %0d, expected %0d", last_err_cyc, last_acc_cyc + 1); end
    tests++; if (obs_pay.size() != 2) begin fails++; $display("FAIL lenerr_pay_count: got %0d, expected 2", obs_pay.size()); end
    for (int i = 0; i < obs_pay.size() && i < 2; i++) begin
      tests++; if (obs_pay[i] !== tx_q[i+1]) begin fails++; $display("FAIL lenerr_pay_beat%0d: got %h, expected %h", i, obs_pay[i], tx_q[i+1]); end
    end
  endtask

  task automatic test_hdr_only();
    clear_obs();
    make_hdr(LOCAL_ID, 8'h33, 8'h44, 16'd0, 64'h5555_6666_7777_8888, 1'b1);
    model_pkt();
    send_pkt(tx_q.size());
    drain();
    tests++; if (obs_hdr.size() != 1) begin fails++; $display("FAIL hdronly0_hdr_count: got %0d, expected 1", obs_hdr.size()); end
    tests++; if (obs_pay.size() != 0) begin fails++; $display("FAIL hdronly0_pay_count: got %0d, expected 0", obs_pay.size()); end
    tests++; if (err_pulses - err_base != 0) begin fails++; $display("FAIL hdronly0_len_err: got %0d pulses, expected 0", err_pulses - err_base); end
    clear_obs();
    make_hdr(LOCAL_ID, 8'h34, 8'h45, 16'd16, 64'h9999_AAAA_BBBB_CCCC, 1'b1);
    model_pkt();
    send_pkt(tx_q.size());
    drain();
    tests++; if (obs_hdr.size() != 1) begin fails++; $display("FAIL hdronly16_hdr_count: got %0d, expected 1", obs_hdr.size()); end
    if (obs_hdr.size() > 0) begin
      tests++; if (obs_hdr[0].len !== 16'd16) begin fails++; $display("FAIL hdronly16_len: got %0d, expected 16", obs_hdr[0].len); end
    end
    tests++; if (err_pulses - err_base != 1) begin fails++; $display("FAIL hdronly16_len_err: got %0d pulses, expected 1", err_pulses - err_base); end
  endtask

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    clear_obs();
    stab_en = 1'b1;
    fork
      begin
        for (int p = 0; p < 200; p++) begin
          gen_random_pkt();
          model_pkt();
          send_pkt(tx_q.size());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.io_hdr_ready = 1'($urandom_range(0, 1));
          bus.io_pay_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    bus.io_hdr_ready = 1'b1;
    bus.io_pay_ready = 1'b1;
    drain();
    stab_en = 1'b0;
    tests++; if (obs_hdr.size() != exp_hdr.size()) begin fails++; $display("FAIL b2b_hdr_count: got %0d, expected %0d", obs_hdr.size(), exp_hdr.size()); end
    for (int i = 0; i < obs_hdr.size() && i < exp_hdr.size(); i++) begin
      tests++; if (obs_hdr[i] !== exp_hdr[i]) begin fails++; $display("FAIL b2b_hdr%0d: got %h, expected %h", i, obs_hdr[i], exp_hdr[i]); end
    end
    tests++; if (obs_pay.size() != exp_pay.size()) begin fails++; $display("FAIL b2b_pay_count: got %0d, expected %0d", obs_pay.size(), exp_pay.size()); end
    for (int i = 0; i < obs_pay.size() && i < exp_pay.size(); i++) begin
      tests++; if (obs_pay[i] !== exp_pay[i]) begin fails++; $display("FAIL b2b_pay%0d: got %h, expected %h", i, obs_pay[i], exp_pay[i]); end
    end
    tests++; if (pkt_cnt !== 32'(exp_pkt)) begin fails++; $display("FAIL b2b_pkt_cnt: got %0d, expected %0d", pkt_cnt, exp_pkt); end
    tests++; if (drop_cnt !== 32'(exp_drop)) begin fails++; $display("FAIL b2b_drop_cnt: got %0d, expected %0d", drop_cnt, exp_drop); end
    tests++; if (err_pulses - err_base != exp_err) begin fails++; $display("FAIL b2b_len_err: got %0d pulses, expected %0d", err_pulses - err_base, exp_err); end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL b2b_stability: got %0d unstable cycles, expected 0", stab_err); end

    // Full throughput with both sinks held ready
    clear_obs();
    make_hdr(LOCAL_ID, 8'h66, 8'h77, 16'd96, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0);
    for (int i = 0; i < 6; i++) add_beat(4'hF, i == 5);
    model_pkt();
    send_pkt(tx_q.size());
    drain();
    tests++; if (stalls != 0) begin fails++; $display("FAIL tput_stalls: got %0d, expected 0", stalls); end
    tests++; if (obs_pay.size() != 6) begin fails++; $display("FAIL tput_pay_count: got %0d, expected 6", obs_pay.size()); end
    if (obs_pay_cyc.size() == 6) begin
      tests++; if (obs_pay_cyc[5] - obs_pay_cyc[0] != 5) begin fails++; $display("FAIL tput_span: got %0d cycles, expected 5", obs_pay_cyc[5] - obs_pay_cyc[0]); end
    end
    tests++; if (err_pulses - err_base != 0) begin fails++; $display("FAIL tput_len_err: got %0d pulses, expected 0", err_pulses - err_base); end
  endtask

  task automatic test_async_reset();
    clear_obs();
    bus.io_hdr_ready = 1'b0;
    bus.io_pay_ready = 1'b0;
    make_hdr(LOCAL_ID, 8'h10, 8'h20, 16'd48, 64'hAAAA_0000_BBBB_1111, 1'b0);
    add_beat(4'hF, 1'b0);
    add_beat(4'hF, 1'b0);
    add_beat(4'hF, 1'b1);
    send_pkt(2);
    @(negedge clk);
    tests++; if (bus.io_hdr_valid !== 1'b1 || bus.io_pay_valid !== 1'b1) begin fails++; $display("FAIL arst_pre_valids: got hdr %b pay %b, expected 1 1", bus.io_hdr_valid, bus.io_pay_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.io_hdr_valid !== 1'b0) begin fails++; $display("FAIL arst_hdr_valid: got %b, expected 0", bus.io_hdr_valid); end
    tests++; if (bus.io_pay_valid !== 1'b0) begin fails++; $display("FAIL arst_pay_valid: got %b, expected 0", bus.io_pay_valid); end
    tests++; if (pkt_cnt !== 32'd0) begin fails++; $display("FAIL arst_pkt_cnt: got %0d, expected 0", pkt_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();
    exp_pkt = 0;
    exp_drop = 0;
    clear_obs();
    bus.io_hdr_ready = 1'b1;
    bus.io_pay_ready = 1'b1;
    make_hdr(LOCAL_ID, 8'h77, 8'h88, 16'd4, 64'h1234_0000_0000_5678, 1'b0);
    add_beat(4'h1, 1'b1);
    model_pkt();
    send_pkt(tx_q.size());
    drain();
    tests++; if (obs_hdr.size() != 1) begin fails++; $display("FAIL arst_post_hdr_count: got %0d, expected 1", obs_hdr.size()); end
    if (obs_hdr.size() > 0) begin
      tests++; if (obs_hdr[0] !== exp_hdr[0]) begin fails++; $display("FAIL arst_post_hdr: got %h, expected %h", obs_hdr[0], exp_hdr[0]); end
    end
    tests++; if (obs_pay.size() != 1) begin fails++; $display("FAIL arst_post_pay_count: got %0d, expected 1", obs_pay.size()); end
    if (obs_pay.size() > 0) begin
      tests++; if (obs_pay[0] !== tx_q[1]) begin fails++; $display("FAIL arst_post_pay: got %h, expected %h", obs_pay[0], tx_q[1]); end
    end
    tests++; if (pkt_cnt !== 32'(exp_pkt)) begin fails++; $display("FAIL arst_post_pkt_cnt: got %0d, expected %0d", pkt_cnt, exp_pkt); end
    tests++; if (err_pulses - err_base != 0) begin fails++; $display("FAIL arst_post_len_err: got %0d pulses, expected 0", err_pulses - err_base); end
  endtask

  initial begin
    test_reset();
    test_local_packet();
    test_foreign_packet();
    test_len_err();
    test_hdr_only();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
